// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants, state encoding and nibble-count helper for the
// nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder4_slice.sv
// 4-bit ripple-carry adder: two half adders per bit, carries merged with OR.
module adder4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] carry;
  logic [3:0] p;
  logic [3:0] g1;
  logic [3:0] g2;

  always_comb begin
    carry    = '0;
    p        = '0;
    g1       = '0;
    g2       = '0;
    s        = '0;
    carry[0] = c;
    for (int unsigned i = 0; i < 4; i++) begin
      p[i]       = a[i] ^ b[i];
      g1[i]      = a[i] & b[i];
      s[i]       = p[i] ^ carry[i];
      g2[i]      = p[i] & carry[i];
      carry[i+1] = g1[i] | g2[i];
    end
  end

  assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequencer reusing one 4-bit adder slice,
// one nibble per clock, LSB first, with start/busy/done handshake.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NIB   = nib_count(WIDTH);
  localparam int unsigned IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       slice_s;
  logic             slice_cout;

  adder4_slice u_slice (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .c    (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Slice result enters at the top so the LSB nibble ends up at the bottom.
        acc_d   = {slice_s, acc_q[WIDTH-1:NIBBLE_W]};
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          sum_d   = {slice_s, acc_q[WIDTH-1:NIBBLE_W]};
          cout_d  = slice_cout;
          ovf_d   = (a_q[3] == b_q[3]) & (slice_s[3] != a_q[3]);
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
